territory_tally: RTL and testbench
==================================

Name: territory_tally

Overview:
- Scans the 160x120x3 framebuffer RAM after the round timer expires and counts the pixels owned by each of the four players.
- Determines the winner and presents it to the draw datapath, which then paints the winner marker.
- Sits directly upstream of the draw datapath's winner input.
- Owns the RAM read address while busy; the top level muxes the RAM address to this block whenever busy=1.

Parameters:
- X_MAX, 159, last valid X coordinate (address bits [14:7]).
- Y_MAX, 119, last valid Y coordinate (address bits [6:0]).
- RAM_LATENCY, 1, cycles from address presented to ram_q valid (synchronous read).
- CNT_W, 15, count width; must satisfy 2^CNT_W > (X_MAX+1)*(Y_MAX+1).

Ports:
- CLOCK_50, in, 1, system clock; all logic on the rising edge.
- resetn, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse requesting a scan; the top level drives it from the falling edge of running.
- ram_address, out, 15, {x[7:0], y[6:0]} read address.
- ram_q, in, 3, RAM read data, valid RAM_LATENCY cycles after its address.
- busy, out, 1, high from the cycle after start is accepted until done rises.
- done, out, 1, level; high once results are valid, held until the next accepted start or reset.
- p1_count, p2_count, p3_count, p4_count, out, CNT_W each, pixels owned by each player.
- winner, out, 2, index of the player with the largest count (0=p1 .. 3=p4).
- tie, out, 1, set when two or more players share the maximum count.

Behaviour:
- Reset values (resetn=0, asynchronous): state=IDLE, ram_address=0, busy=0, done=0, all counts=0, winner=0, tie=0.
- Colour ownership: 3'b001=p1, 3'b010=p2, 3'b100=p3, 3'b110=p4. All other codes (000 background, 111 timer bar, 011, 101) are not counted.
- FSM states: IDLE, SCAN, DRAIN, CMP1, CMP2, DONE.
- IDLE: on start=1, clear all counts and x/y counters, go to SCAN. done=0 from the next cycle.
- SCAN: present ram_address={x,y} each cycle. y increments 0..Y_MAX, then wraps to 0 with x+1. Addresses with y>Y_MAX are never issued.
  - After {X_MAX,Y_MAX} is issued, go to DRAIN.
  - Exactly (X_MAX+1)*(Y_MAX+1)=19200 addresses are issued, one per cycle, no gaps.
- Read pipeline: a valid flag is delayed by RAM_LATENCY stages alongside the address. A count increments only when the delayed valid=1 and ram_q matches that player's code. At most one count increments per cycle.
- DRAIN: hold for RAM_LATENCY cycles so the last RAM word is counted, then go to CMP1.
- CMP1: register pairwise winners (p1 vs p2, p3 vs p4) using strict >, so the lower index wins equality.
- CMP2: register the final winner (same rule) and tie = (number of counts equal to the maximum) >= 2. Go to DONE.
- DONE: done=1, busy=0. Results are held stable. start=1 re-enters the scan exactly as from IDLE.
- Latency: done rises exactly 19200 + RAM_LATENCY + 3 cycles after the edge that samples start.
  - 1 cycle entry, 19200 scan, RAM_LATENCY drain, 2 compare.
- start while busy is ignored; the scan is not restarted.
- All counts zero -> winner=0, tie=1.
- Count saturation is impossible: max count 19200 < 2^15. Counts are unsigned with no wrap.
- Reset mid-scan: immediate return to reset values. A later start performs a full scan.
- ram_address is held at its last value outside SCAN. The block never writes the RAM.

Decomposition:
- Shared package tron_pkg holds:
  - player colour codes P1_COL..P4_COL;
  - SCREEN_W=160, SCREEN_H=120;
  - the address-field split (X at [14:7], Y at [6:0]);
  - the tally_state_t enum.
- One natural sub-module: tally_argmax. It is a two-stage registered 4-way argmax with lowest-index tie-break and a tie flag, used for CMP1/CMP2.

Test Plan:
- RAM model all 000, start pulse -> done exactly 19204 cycles later (RAM_LATENCY=1); counts all 0, winner=0, tie=1.
- 100 pixels 010 and 50 pixels 100 scattered, rest 000 -> p2_count=100, p3_count=50, others 0, winner=1, tie=0.
- 300 pixels 001 and 300 pixels 110, plus 40 pixels 111 -> p1=p4=300, winner=0, tie=1, 111 pixels not counted.
- Every pixel at y=120..127 preloaded 001 and visible area 000 -> p1_count=0. Monitor confirms no address with y>119 is issued and the address sequence is 0x0000, 0x0001 .. 0x0077, 0x0080 ..
- Assert resetn=0 at scan cycle 5000, release, then start -> outputs return to 0 immediately; the second scan produces the correct counts in 19204 cycles.
- start pulsed again at scan cycle 100 -> ignored, done timing unchanged. start in DONE after changing RAM contents -> counts cleared, new results reported.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared Tron definitions: player colours, screen geometry, framebuffer
// address split and the territory tally FSM encoding.
package tron_pkg;

    localparam int SCREEN_W    = 160;
    localparam int SCREEN_H    = 120;
    localparam int NUM_PLAYERS = 4;

    localparam int ADDR_W = 15;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int X_LSB  = 7;
    localparam int Y_LSB  = 0;

    localparam logic [2:0] P1_COL = 3'b001;
    localparam logic [2:0] P2_COL = 3'b010;
    localparam logic [2:0] P3_COL = 3'b100;
    localparam logic [2:0] P4_COL = 3'b110;

    localparam logic [NUM_PLAYERS-1:0][2:0] PLAYER_COL = {P4_COL, P3_COL, P2_COL, P1_COL};

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        CMP1,
        CMP2,
        DONE
    } tally_state_t;

endpackage

// File: rtl/territory_tally_if.sv
// Scan request, framebuffer read port and result bus of territory_tally.
interface territory_tally_if import tron_pkg::*; #(
    parameter int CNT_W = 15
);
    logic              start;
    logic [ADDR_W-1:0] ram_address;
    logic [2:0]        ram_q;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  p1_count;
    logic [CNT_W-1:0]  p2_count;
    logic [CNT_W-1:0]  p3_count;
    logic [CNT_W-1:0]  p4_count;
    logic [1:0]        winner;
    logic              tie;

    modport master (
        output start, ram_q,
        input  ram_address, busy, done, p1_count, p2_count, p3_count, p4_count, winner, tie
    );

    modport slave (
        input  start, ram_q,
        output ram_address, busy, done, p1_count, p2_count, p3_count, p4_count, winner, tie
    );
endinterface

// File: rtl/tally_argmax.sv
// Two-stage registered 4-way argmax: pairwise in stage 1, final plus tie
// flag in stage 2. Strict > everywhere so the lower index wins equality.
module tally_argmax import tron_pkg::*; #(
    parameter int CNT_W = 15
) (
    input  logic                              CLOCK_50,
    input  logic                              resetn,
    input  logic                              en1,
    input  logic                              en2,
    input  logic [NUM_PLAYERS-1:0][CNT_W-1:0] cnt,
    output logic [1:0]                        winner,
    output logic                              tie
);
    logic [CNT_W-1:0] m01, m23, mx;
    logic             w01, w23, hi;
    logic [2:0]       n_eq;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            w01 <= 1'b0;
            w23 <= 1'b0;
            m01 <= '0;
            m23 <= '0;
        end else if (en1) begin
            w01 <= cnt[1] > cnt[0];
            w23 <= cnt[3] > cnt[2];
            m01 <= (cnt[1] > cnt[0]) ? cnt[1] : cnt[0];
            m23 <= (cnt[3] > cnt[2]) ? cnt[3] : cnt[2];
        end
    end

    // counts are frozen while comparing, so stage 2 may read them live
    always_comb begin
        hi   = m23 > m01;
        mx   = hi ? m23 : m01;
        n_eq = '0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (cnt[i] == mx) n_eq = n_eq + 3'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            winner <= 2'd0;
            tie    <= 1'b0;
        end else if (en2) begin
            winner <= hi ? {1'b1, w23} : {1'b0, w01};
            tie    <= n_eq >= 3'd2;
        end
    end
endmodule

// File: rtl/territory_tally.sv
// Post-round framebuffer scan: counts each player's pixels and reports the
// winner. Drives the RAM read address while busy.
module territory_tally import tron_pkg::*; #(
    parameter int X_MAX       = SCREEN_W - 1,
    parameter int Y_MAX       = SCREEN_H - 1,
    parameter int RAM_LATENCY = 1,
    parameter int CNT_W       = 15
) (
    input logic        CLOCK_50,
    input logic        resetn,
    territory_tally_if.slave bus
);
    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

    tally_state_t                      state;
    logic [X_W-1:0]                    x;
    logic [Y_W-1:0]                    y;
    logic [RAM_LATENCY:0]              vld_pipe;
    logic [NUM_PLAYERS-1:0][CNT_W-1:0] cnt;
    logic                              start_ok, last_addr, drained;

    assign start_ok  = bus.start && (state == IDLE || state == DONE);
    assign last_addr = (x == X_LAST) && (y == Y_LAST);
    // leave DRAIN on the edge that counts the final word, so CMP1 sees it
    assign drained   = (vld_pipe[RAM_LATENCY-1:0] == '0);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            x               <= '0;
            y               <= '0;
            bus.ram_address <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state    <= SCAN;
                    x        <= '0;
                    y        <= '0;
                    bus.busy <= 1'b1;
                    bus.done <= 1'b0;
                end
                SCAN: begin
                    bus.ram_address <= {x, y};
                    if (last_addr) begin
                        state <= DRAIN;
                    end else if (y == Y_LAST) begin
                        y <= '0;
                        x <= x + 1'b1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end
                DRAIN: if (drained) state <= CMP1;
                CMP1:  state <= CMP2;
                CMP2: begin
                    state    <= DONE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // valid bit rides alongside the address through the RAM read latency
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) vld_pipe <= '0;
        else         vld_pipe <= {vld_pipe[RAM_LATENCY-1:0], state == SCAN};
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (start_ok) begin
            cnt <= '0;
        end else if (vld_pipe[RAM_LATENCY]) begin
            for (int i = 0; i < NUM_PLAYERS; i++)
                if (bus.ram_q == PLAYER_COL[i]) cnt[i] <= cnt[i] + 1'b1;
        end
    end

    tally_argmax #(.CNT_W(CNT_W)) u_argmax (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .en1      (state == CMP1),
        .en2      (state == CMP2),
        .cnt      (cnt),
        .winner   (bus.winner),
        .tie      (bus.tie)
    );

    assign bus.p1_count = cnt[0];
    assign bus.p2_count = cnt[1];
    assign bus.p3_count = cnt[2];
    assign bus.p4_count = cnt[3];
endmodule

// File: tb/tb_territory_tally.sv
// Directed bench for territory_tally: framebuffer RAM model, scoreboard of
// expected tallies pushed at start and popped when done rises.
module tb_territory_tally;
    import tron_pkg::*;

    localparam int LAT = 19204;

    typedef struct packed {
        logic [3:0][14:0] c;
        logic [1:0]       w;
        logic             t;
    } exp_t;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    territory_tally_if bus ();

    territory_tally dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    logic [2:0] mem [32768];
    exp_t       sb [$];
    int         total = 0;
    int         passed = 0;
    int         yviol = 0;

    always @(posedge CLOCK_50) bus.ram_q <= mem[bus.ram_address];

    always @(negedge CLOCK_50)
        if (resetn && bus.busy === 1'b1 && bus.ram_address[6:0] > 7'd119) yviol++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 32768; a++) mem[a] = 3'b000;
    endtask

    task automatic put(input int lin, input logic [2:0] v);
        mem[((lin / 120) << 7) | (lin % 120)] = v;
    endtask

    function automatic exp_t model();
        exp_t        e;
        logic [14:0] mx;
        int          n;
        e = '0;
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                case (mem[(x << 7) | y])
                    3'b001:  e.c[0] = e.c[0] + 1;
                    3'b010:  e.c[1] = e.c[1] + 1;
                    3'b100:  e.c[2] = e.c[2] + 1;
                    3'b110:  e.c[3] = e.c[3] + 1;
                    default: ;
                endcase
        mx = 0;
        for (int i = 0; i < 4; i++) if (e.c[i] > mx) mx = e.c[i];
        n = 0;
        for (int i = 3; i >= 0; i--)
            if (e.c[i] == mx) begin
                e.w = 2'(i);
                n++;
            end
        e.t = n >= 2;
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge CLOCK_50);
        bus.start = 1'b1;
        @(posedge CLOCK_50);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_scan(input string tag, input bit glitch, input bit seqchk);
        exp_t        e;
        int          cyc, bad;
        logic [14:0] ea;
        sb.push_back(model());
        pulse_start();
        cyc = 0;
        bad = 0;
        while (cyc < 20000) begin
            @(posedge CLOCK_50);
            #1 cyc++;
            if (cyc == 1) begin
                chk({tag, "_busy1"}, bus.busy, 1);
                chk({tag, "_done1"}, bus.done, 0);
            end
            bus.start = glitch && (cyc == 100);
            if (seqchk && cyc <= 300) begin
                ea = 15'(((cyc - 1) / 120) << 7 | ((cyc - 1) % 120));
                if (bus.ram_address !== ea) bad++;
            end
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, cyc, LAT);
        if (seqchk) chk({tag, "_addr_seq_errs"}, bad, 0);
        e = sb.pop_front();
        chk({tag, "_p1"}, bus.p1_count, e.c[0]);
        chk({tag, "_p2"}, bus.p2_count, e.c[1]);
        chk({tag, "_p3"}, bus.p3_count, e.c[2]);
        chk({tag, "_p4"}, bus.p4_count, e.c[3]);
        chk({tag, "_winner"}, bus.winner, e.w);
        chk({tag, "_tie"}, bus.tie, e.t);
        chk({tag, "_busy_end"}, bus.busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, bus.ram_address, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_counts"}, {bus.p1_count, bus.p2_count} | {bus.p3_count, bus.p4_count}, 0);
        chk({tag, "_winner"}, bus.winner, 0);
        chk({tag, "_tie"}, bus.tie, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        clear_mem();
        repeat (3) @(posedge CLOCK_50);
        #1 chk_zero("reset");
        @(negedge CLOCK_50) resetn = 1'b1;

        run_scan("zero", 1'b0, 1'b0);
        chk("zero_tie_expected", sb.size(), 0);

        clear_mem();
        for (int i = 0; i < 100; i++) put(i * 191, 3'b010);
        for (int i = 0; i < 50; i++) put(i * 191 + 95, 3'b100);
        run_scan("p2p3", 1'b0, 1'b0);

        clear_mem();
        for (int i = 0; i < 300; i++) begin
            put(i * 3, 3'b001);
            put(i * 3 + 1, 3'b110);
        end
        for (int i = 0; i < 40; i++) put(i * 3 + 2, 3'b111);
        run_scan("p1p4", 1'b0, 1'b0);

        clear_mem();
        for (int x = 0; x < 160; x++)
            for (int y = 120; y < 128; y++) mem[(x << 7) | y] = 3'b001;
        run_scan("offscreen", 1'b0, 1'b1);

        clear_mem();
        for (int i = 0; i < 5; i++) put(i * 3000 + 7, 3'b110);
        for (int i = 0; i < 3; i++) put(i * 4000 + 11, 3'b001);
        for (int i = 0; i < 7; i++) put(i * 50 + 2, 3'b011);
        pulse_start();
        repeat (5000) @(posedge CLOCK_50);
        #1 resetn = 1'b0;
        #1 chk_zero("midreset");
        @(negedge CLOCK_50) resetn = 1'b1;
        run_scan("after_rst", 1'b0, 1'b0);

        run_scan("glitch", 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) put(i * 1000 + 500, 3'b100);
        run_scan("redo", 1'b0, 1'b0);

        chk("y_over_119_issued", yviol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
